regfile_write_arbiter: RTL

- Shares the register file's single write port (regWrite / writeRegister / writeData) between NUM_REQ writeback requesters using round-robin arbitration with a valid/ready handshake.
- Also contains a clear sequencer that sweeps zero into every architectural register except the hardwired zero register, one register per cycle.
- Sits between the writeback sources (ALU, load unit, etc.) and the register file write port.
- All write-port outputs are registered.

---
 rtl/regfile_write_arbiter.sv | 156 +++++++++++++++
 1 files changed

// File: rtl/regfile_write_arbiter.sv
// Register file write-port arbiter: round-robin sharing of the single write
// port between NUM_REQ writeback sources, plus a sequencer that sweeps zero
// into every architectural register except the hardwired zero register.
module regfile_write_arbiter #(
    parameter int unsigned NUM_REQ  = 4,
    parameter int unsigned DATA_W   = 64,
    parameter int unsigned ADDR_W   = 5,
    parameter int unsigned ZERO_REG = 31
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [NUM_REQ-1:0]        req_valid,
    output logic [NUM_REQ-1:0]        req_ready,
    input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
    input  logic [NUM_REQ*DATA_W-1:0] req_data,
    input  logic                      clear_start,
    output logic                      clear_busy,
    output logic                      clear_done,
    output logic                      regWrite,
    output logic [ADDR_W-1:0]         writeRegister,
    output logic [DATA_W-1:0]         writeData
);

    localparam int unsigned PTR_W      = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int unsigned NUM_REGS   = 32'(1) << ADDR_W;
    localparam int unsigned FIRST_ADDR = (ZERO_REG == 0) ? 1 : 0;
    localparam int unsigned LAST_ADDR  = (ZERO_REG == NUM_REGS - 1) ? NUM_REGS - 2 : NUM_REGS - 1;

    localparam logic [0:0] ST_ARB   = 1'b0;
    localparam logic [0:0] ST_CLEAR = 1'b1;

    // State and registered outputs
    logic [0:0]        state;
    logic [PTR_W-1:0]  ptr;
    logic [ADDR_W-1:0] cnt;

    // Next-state values
    logic [0:0]        state_nx;
    logic [PTR_W-1:0]  ptr_nx;
    logic [ADDR_W-1:0] cnt_nx;
    logic              we_nx;
    logic [ADDR_W-1:0] waddr_nx;
    logic [DATA_W-1:0] wdata_nx;
    logic              busy_nx;
    logic              done_nx;

    // Arbitration intermediates
    logic [PTR_W:0]    rot;
    logic              grant_any;
    logic [PTR_W-1:0]  grant_idx;
    logic              grant;
    logic [ADDR_W-1:0] sel_addr;
    logic [DATA_W-1:0] sel_data;

    // Round-robin search: first valid requester at or after the pointer, with wrap
    always_comb begin
        rot       = '0;
        grant_any = 1'b0;
        grant_idx = '0;
        for (int unsigned k = 0; k < NUM_REQ; k++) begin
            rot = {1'b0, ptr} + (PTR_W+1)'(k);
            if (rot >= (PTR_W+1)'(NUM_REQ)) begin
                rot = rot - (PTR_W+1)'(NUM_REQ);
            end
            if (!grant_any && req_valid[rot[PTR_W-1:0]]) begin
                grant_any = 1'b1;
                grant_idx = rot[PTR_W-1:0];
            end
        end
    end

    // Grant only in ARB and only when no clear is being requested this cycle
    always_comb begin
        grant     = grant_any && (state == ST_ARB) && !clear_start;
        req_ready = '0;
        if (grant) begin
            req_ready[grant_idx] = 1'b1;
        end
        sel_addr = req_addr[grant_idx*ADDR_W +: ADDR_W];
        sel_data = req_data[grant_idx*DATA_W +: DATA_W];
    end

    // Next-state and next-output logic for arbitration and clear sweep
    always_comb begin
        state_nx = state;
        ptr_nx   = ptr;
        cnt_nx   = cnt;
        we_nx    = 1'b0;
        waddr_nx = writeRegister;
        wdata_nx = writeData;
        busy_nx  = 1'b0;
        done_nx  = 1'b0;

        case (state)
            ST_ARB: begin
                if (clear_start) begin
                    state_nx = ST_CLEAR;
                    cnt_nx   = ADDR_W'(FIRST_ADDR);
                    busy_nx  = 1'b1;
                end else if (grant) begin
                    ptr_nx = (grant_idx == PTR_W'(NUM_REQ - 1)) ? '0 : grant_idx + PTR_W'(1);
                    // Writes aimed at the hardwired zero register complete but are dropped
                    if (sel_addr != ADDR_W'(ZERO_REG)) begin
                        we_nx    = 1'b1;
                        waddr_nx = sel_addr;
                        wdata_nx = sel_data;
                    end
                end
            end

            ST_CLEAR: begin
                we_nx    = 1'b1;
                waddr_nx = cnt;
                wdata_nx = '0;
                if (cnt == ADDR_W'(LAST_ADDR)) begin
                    state_nx = ST_ARB;
                    done_nx  = 1'b1;
                end else begin
                    busy_nx = 1'b1;
                    cnt_nx  = cnt + ADDR_W'(1);
                    if (cnt_nx == ADDR_W'(ZERO_REG)) begin
                        cnt_nx = cnt + ADDR_W'(2);
                    end
                end
            end

            default: begin
                state_nx = ST_ARB;
            end
        endcase
    end

    // State register and registered write-port / status outputs
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state         <= ST_ARB;
            ptr           <= '0;
            cnt           <= '0;
            regWrite      <= 1'b0;
            writeRegister <= '0;
            writeData     <= '0;
            clear_busy    <= 1'b0;
            clear_done    <= 1'b0;
        end else begin
            state         <= state_nx;
            ptr           <= ptr_nx;
            cnt           <= cnt_nx;
            regWrite      <= we_nx;
            writeRegister <= waddr_nx;
            writeData     <= wdata_nx;
            clear_busy    <= busy_nx;
            clear_done    <= done_nx;
        end
    end

endmodule
